// File: rtl/inst_encoder_if.sv
// Field-set input and encoded-word output bus of the instruction encoder.
// master drives the field sets and consumes words; slave is the encoder.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rsa;
    logic [4:0]  rta;
    logic [4:0]  wta;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] addr;

    modport master (
        output in_valid, fmt, opcode, func, rsa, rta, wta, shift, imm, out_ready,
        input  in_ready, out_valid, inst, addr
    );

    modport slave (
        input  in_valid, fmt, opcode, func, rsa, rta, wta, shift, imm, out_ready,
        output in_ready, out_valid, inst, addr
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded fields into MIPS R/I/J words, rejects out-of-range immediates
// and targets, and queues legal words in a FIFO tagged with sequential addresses.
module inst_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    inst_encoder_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [7:0]             err_cnt
);

    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    localparam logic [1:0] ERR_IMM     = 2'd1;
    localparam logic [1:0] ERR_TARGET  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   addr_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic [1:0]  enc_code;

    logic accept;
    logic push;
    logic pop;
    logic reject;

    // An I immediate fits in 16 bits only when bits 31:15 are pure sign copies.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        enc_code  = ERR_ILLEGAL;
        case (bus.fmt)
            FMT_R: begin
                enc_word  = {bus.opcode, bus.rsa, bus.rta, bus.wta, bus.shift, bus.func};
                enc_legal = 1'b1;
            end
            FMT_I: begin
                enc_word  = {bus.opcode, bus.rsa, bus.rta, bus.imm[15:0]};
                enc_legal = (bus.imm[31:15] == '0) || (bus.imm[31:15] == '1);
                enc_code  = ERR_IMM;
            end
            FMT_J: begin
                enc_word  = {bus.opcode, bus.imm[27:2]};
                enc_legal = (bus.imm[1:0] == 2'b00) && (bus.imm[31:28] == 4'h0);
                enc_code  = ERR_TARGET;
            end
            default: begin
                enc_legal = 1'b0;
                enc_code  = ERR_ILLEGAL;
            end
        endcase
    end

    assign bus.in_ready  = (count != FULL_COUNT);
    assign bus.out_valid = (count != '0);
    assign bus.inst      = bus.out_valid ? mem[rd_ptr] : 32'h0;
    assign bus.addr      = addr_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign push   = accept & enc_legal;
    assign reject = accept & ~enc_legal;
    assign pop    = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    // count alone tells full from empty, so the pointers may wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_q   <= BASE_ADDR;
            err      <= 1'b0;
            err_code <= 2'd0;
            err_cnt  <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr_q <= addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (reject) begin
                err      <= 1'b1;
                err_code <= enc_code;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Writer-side counterpart of the instruction decoder: takes decoded fields (opcode, func, register addresses, shift, immediate/target) and packs them into 32-bit MIPS-style R/I/J instruction words.
- Range-checks the immediate, i.e. the inverse of the 16→32 sign extension.
- Buffers encoded words in a small FIFO and emits them with a sequential word address, feeding the instruction-memory loader and testbenches.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
BASE_ADDR, 32'h0000_0000, address reported with the first emitted word after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  field set on inputs is valid
in_ready  output  1  block can accept a field set this cycle
fmt  input  2  0=R, 1=I, 2=J, 3=illegal
opcode  input  6  instruction opcode
func  input  6  R-format function code
rsa  input  5  source register rs
rta  input  5  source/target register rt
wta  input  5  destination register rd (R-format)
shift  input  5  shift amount (R-format)
imm  input  32  I: signed immediate value; J: byte target address
out_valid  output  1  inst/addr valid
out_ready  input  1  consumer accepts inst this cycle
inst  output  32  encoded instruction at FIFO head
addr  output  32  word address of inst
count  output  clog2(DEPTH)+1  FIFO occupancy
err  output  1  sticky: at least one field set rejected since reset
err_code  output  2  cause of most recent rejection: 1=imm range, 2=J alignment/range, 3=illegal fmt
err_cnt  output  8  rejected field sets, saturating at 255

Behaviour:
- Reset (rst=1 at clk edge): FIFO emptied, count=0, out_valid=0, inst=0, addr=BASE_ADDR, err=0, err_code=0, err_cnt=0. Reset wins over any simultaneous handshake; in-flight words are discarded.
- in_ready = (count != DEPTH). Combinational from state only; no same-cycle bypass when full.
- Accept: in_valid & in_ready at clk edge. Field set is encoded combinationally and, if legal, written to the FIFO tail.
- Encoding (bits 31:0):
  - R: opcode[31:26], rsa[25:21], rta[20:16], wta[15:11], shift[10:6], func[5:0].
  - I: opcode[31:26], rsa[25:21], rta[20:16], imm[15:0].
  - J: opcode[31:26], imm[27:2].
- Legality:
  - I requires imm[31:15] all equal (value representable as signed 16-bit); else err_code=1.
  - J requires imm[1:0]==0 and imm[31:28]==0; else err_code=2.
  - fmt=3: err_code=3.
  - R is always legal; unused fields are ignored.
- Rejected accept: the handshake still completes (in_ready honoured) and nothing is enqueued. err←1, err_code updated, err_cnt+1 unless it is already 255.
- Output:
  - out_valid = (count != 0).
  - inst = FIFO head when out_valid, else 0.
  - Pop on out_valid & out_ready.
- Latency: a word accepted at edge N appears on inst at edge N (registered), visible the cycle after accept; minimum 1 cycle.
- Address: addr holds the address of the current head. It increments by 4 on each pop, wraps modulo 2^32, and is unaffected by rejections.
- Simultaneous push and pop:
  - Non-empty, not full: count unchanged, order preserved.
  - Full: pop only (in_ready=0).
  - Empty: push only.
- Pointers are clog2(DEPTH) bits and wrap naturally. count is the sole full/empty discriminator.
- out_valid, once high, stays high with inst/addr stable until popped.

Test Plan:
- R encode: fmt=0, opcode=0, rsa=1, rta=2, wta=3, shift=0, func=0x20, out_ready=1 → inst=0x00221820, addr=0x00000000, out_valid for 1 cycle.
- I encode, negative imm: fmt=1, opcode=0x08, rsa=1, rta=2, imm=0xFFFFFFFF → inst=0x2022FFFF. Then imm=0x00008000 → not enqueued, err=1, err_code=1, err_cnt=1; next legal word still gets addr=0x00000004.
- J encode: fmt=2, opcode=0x02, imm=0x00400000 → inst=0x08100000. Then imm=0x00400002 → err_code=2, no output.
- Backpressure: out_ready=0, push 5 legal words → 4 accepted, in_ready=0 after 4th, count=4. Raise out_ready → words drain in order with addr 0,4,8,C; 5th accepted once count=3.
- Concurrent push/pop at count=2 for 10 cycles → count stays 2, no loss/duplication. With BASE_ADDR=0xFFFFFFFC, second word's addr wraps to 0x00000000.
- Reset mid-operation: count=3, err=1, assert rst one cycle with in_valid=1 → count=0, out_valid=0, inst=0, err=0, err_cnt=0, addr=BASE_ADDR, input not enqueued.
